// File: rtl/pls_stretch_if.sv
// Pulse-stretcher port bundle: pulse/enable/clear inputs and level/status outputs.
// master drives pulses and observes status; slave is the stretcher itself.
interface pls_stretch_if #(
   parameter int PEND_W = 3
);
   logic              p;
   logic              en;
   logic              clr_ovf;
   logic              lvl;
   logic              busy;
   logic [PEND_W-1:0] pend_cnt;
   logic              ovf;

   modport master (
      output p, en, clr_ovf,
      input  lvl, busy, pend_cnt, ovf
   );

   modport slave (
      input  p, en, clr_ovf,
      output lvl, busy, pend_cnt, ovf
   );
endinterface

// File: rtl/pls_stretch.sv
// Stretches single-cycle pulses into HIGH_CYC-wide windows followed by GAP_CYC low
// cycles; pulses arriving while busy are counted and replayed in order.
module pls_stretch #(
   parameter int HIGH_CYC = 4,
   parameter int GAP_CYC  = 2,
   parameter int PEND_W   = 3
) (
   input  logic         clk,
   input  logic         reset,
   pls_stretch_if.slave bus
);
   localparam int MAXC = (HIGH_CYC > GAP_CYC) ? HIGH_CYC : GAP_CYC;
   localparam int TW   = $clog2(MAXC + 1);
   localparam logic [TW-1:0]     HRLD = TW'(HIGH_CYC - 1);
   localparam logic [TW-1:0]     GRLD = TW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
   localparam logic [PEND_W-1:0] PMAX = {PEND_W{1'b1}};

   typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;

   state_t            state, state_nx;
   logic [TW-1:0]     tmr, tmr_nx;
   logic [PEND_W-1:0] pend, pend_nx;
   logic              lvl, lvl_nx;
   logic              ovf, ovf_nx;
   logic              acc;
   logic              deq_pt;

   assign acc = bus.p & bus.en;

   // Edge at which the current window (and its gap, if any) has fully elapsed.
   assign deq_pt = (tmr == '0) &&
                   ((state == GAP) || ((state == HIGH) && (GAP_CYC == 0)));

   always_comb begin
      state_nx = state;
      tmr_nx   = tmr;
      pend_nx  = pend;
      lvl_nx   = lvl;
      ovf_nx   = bus.clr_ovf ? 1'b0 : ovf;
      case (state)
         IDLE: begin
            if (acc) begin
               state_nx = HIGH;
               tmr_nx   = HRLD;
               lvl_nx   = 1'b1;
            end
         end
         default: begin
            if (deq_pt) begin
               // A pulse accepted on this edge either starts directly or swaps
               // with the one being dequeued, so the counter never overflows here.
               if (acc || (pend != '0)) begin
                  state_nx = HIGH;
                  tmr_nx   = HRLD;
                  lvl_nx   = 1'b1;
                  if (!acc) pend_nx = pend - 1'b1;
               end else begin
                  state_nx = IDLE;
                  tmr_nx   = '0;
                  lvl_nx   = 1'b0;
               end
            end else begin
               if (acc) begin
                  if (pend == PMAX) ovf_nx  = 1'b1;
                  else              pend_nx = pend + 1'b1;
               end
               if (tmr != '0) begin
                  tmr_nx = tmr - 1'b1;
               end else begin
                  state_nx = GAP;
                  tmr_nx   = GRLD;
                  lvl_nx   = 1'b0;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         tmr   <= '0;
         pend  <= '0;
         lvl   <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         state <= state_nx;
         tmr   <= tmr_nx;
         pend  <= pend_nx;
         lvl   <= lvl_nx;
         ovf   <= ovf_nx;
      end
   end

   assign bus.lvl      = lvl;
   assign bus.busy     = (state != IDLE) || (pend != '0);
   assign bus.pend_cnt = pend;
   assign bus.ovf      = ovf;
endmodule

// File: tb/tb_pls_stretch.sv
// Bench for pls_stretch: two instances (with and without a gap) share one stimulus
// stream; a timeline model of window start edges predicts every output after each edge.
module tb_pls_stretch;
   localparam int NMAX = 4096;

   typedef struct packed {
      logic       lvl;
      logic       busy;
      logic [2:0] pend;
      logic       ovf;
   } exp_t;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   logic p       = 1'b0;
   logic en      = 1'b0;
   logic clr     = 1'b0;

   int   cyc     = 0;
   int   n_chk   = 0;
   int   n_fail  = 0;

   int   st [2][NMAX];
   int   nst [2];
   logic movf [2];
   exp_t q0[$];
   exp_t q1[$];

   pls_stretch_if #(.PEND_W(3)) b0 ();
   pls_stretch_if #(.PEND_W(2)) b1 ();

   assign b0.p = p;  assign b0.en = en;  assign b0.clr_ovf = clr;
   assign b1.p = p;  assign b1.en = en;  assign b1.clr_ovf = clr;

   pls_stretch #(.HIGH_CYC(4), .GAP_CYC(2), .PEND_W(3)) u0 (
      .clk   (clk),
      .reset (reset_n),
      .bus   (b0)
   );

   pls_stretch #(.HIGH_CYC(4), .GAP_CYC(0), .PEND_W(2)) u1 (
      .clk   (clk),
      .reset (reset_n),
      .bus   (b1)
   );

   always #5 clk = ~clk;

   // Pulses still waiting at edge t: windows scheduled to start strictly after t.
   function automatic int count_after(input int k, input int t);
      int c = 0;
      for (int i = nst[k] - 1; i >= 0 && st[k][i] > t; i--) c++;
      return c;
   endfunction

   task automatic model_step(input int k);
      int   h, g, mx, fr, s;
      logic drop;
      exp_t e;
      h    = 4;
      g    = (k == 0) ? 2 : 0;
      mx   = (k == 0) ? 7 : 3;
      drop = 1'b0;
      if (!reset_n) begin
         nst[k]  = 0;
         movf[k] = 1'b0;
      end else begin
         if (p && en) begin
            if (count_after(k, cyc) >= mx) begin
               drop = 1'b1;
            end else if (nst[k] < NMAX) begin
               fr = (nst[k] == 0) ? cyc : st[k][nst[k]-1] + h + g;
               s  = (cyc > fr) ? cyc : fr;
               st[k][nst[k]] = s;
               nst[k]++;
            end
         end
         if (drop)     movf[k] = 1'b1;
         else if (clr) movf[k] = 1'b0;
      end
      e      = '0;
      e.pend = 3'(count_after(k, cyc));
      e.ovf  = movf[k];
      for (int i = nst[k] - 1; i >= 0; i--) begin
         if (st[k][i] <= cyc) begin
            e.lvl  = (cyc <= st[k][i] + h - 1);
            e.busy = (cyc < st[k][i] + h + g);
            break;
         end
      end
      if (e.pend != 3'd0) e.busy = 1'b1;
      if (k == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   task automatic tick(input logic pi, input logic ei, input logic ci);
      @(negedge clk);
      p = pi; en = ei; clr = ci;
      @(posedge clk);
      cyc++;
      model_step(0);
      model_step(1);
   endtask

   task automatic mid_reset();
      @(negedge clk);
      p = 1'b0; en = 1'b0; clr = 1'b0;
      #1 reset_n = 1'b0;
      @(posedge clk);
      cyc++;
      model_step(0);
      model_step(1);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      cyc++;
      model_step(0);
      model_step(1);
   endtask

   // Monitor: clock edges pop the scoreboard; a reset assertion between edges
   // must clear every output without waiting for a clock.
   always @(posedge clk or negedge reset_n) begin
      logic [5:0] a;
      exp_t       e;
      if (clk) begin
         #2;
         if (q0.size() > 0) begin
            e = q0.pop_front();
            a = {b0.lvl, b0.busy, b0.pend_cnt, b0.ovf};
            n_chk++;
            if (a !== e) begin
               n_fail++;
               $display("FAIL u0_cycle cyc=%0d lvl/busy/pend/ovf got %b want %b", cyc, a, e);
            end
         end
         if (q1.size() > 0) begin
            e = q1.pop_front();
            a = {b1.lvl, b1.busy, 1'b0, b1.pend_cnt, b1.ovf};
            n_chk++;
            if (a !== e) begin
               n_fail++;
               $display("FAIL u1_cycle cyc=%0d lvl/busy/pend/ovf got %b want %b", cyc, a, e);
            end
         end
      end else begin
         #1;
         a = {b0.lvl, b0.busy, b0.pend_cnt, b0.ovf};
         n_chk++;
         if (a !== 6'b0) begin
            n_fail++;
            $display("FAIL u0_async_reset got %b want 000000", a);
         end
         a = {b1.lvl, b1.busy, 1'b0, b1.pend_cnt, b1.ovf};
         n_chk++;
         if (a !== 6'b0) begin
            n_fail++;
            $display("FAIL u1_async_reset got %b want 000000", a);
         end
      end
   end

   initial begin
      nst[0] = 0; nst[1] = 0;
      movf[0] = 1'b0; movf[1] = 1'b0;
      repeat (3) tick(1'b0, 1'b0, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) tick(1'b0, 1'b1, 1'b0);

      // single pulse, then a 3-pulse burst
      tick(1'b1, 1'b1, 1'b0);
      repeat (12) tick(1'b0, 1'b1, 1'b0);
      repeat (3) tick(1'b1, 1'b1, 1'b0);
      repeat (30) tick(1'b0, 1'b1, 1'b0);

      // saturation with 10 back-to-back pulses, drain, then clear ovf
      repeat (10) tick(1'b1, 1'b1, 1'b0);
      repeat (60) tick(1'b0, 1'b1, 1'b0);
      tick(1'b0, 1'b1, 1'b1);
      repeat (3) tick(1'b0, 1'b1, 1'b0);

      // reset mid-window with a queue built up
      repeat (4) tick(1'b1, 1'b1, 1'b0);
      mid_reset();
      repeat (20) tick(1'b0, 1'b1, 1'b0);

      // pulses ignored while disabled; disable mid-window keeps queued work
      for (int i = 0; i < 20; i++) tick(1'(i % 2), 1'b0, 1'b0);
      repeat (3) tick(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 40; i++) tick(1'($urandom_range(0, 1)), 1'b0, 1'b0);

      // two pulses one cycle apart, then clears colliding with saturating accepts
      tick(1'b1, 1'b1, 1'b0);
      tick(1'b0, 1'b1, 1'b0);
      tick(1'b1, 1'b1, 1'b0);
      repeat (20) tick(1'b0, 1'b1, 1'b0);
      repeat (15) tick(1'b1, 1'b1, 1'b1);
      repeat (60) tick(1'b0, 1'b1, 1'b0);

      // randomized traffic with occasional asynchronous resets
      for (int i = 0; i < 1500; i++) begin
         if (i % 400 == 399) mid_reset();
         else tick(1'($urandom_range(0, 2) == 0),
                   1'($urandom_range(0, 9) != 0),
                   1'($urandom_range(0, 19) == 0));
      end
      repeat (60) tick(1'b0, 1'b1, 1'b0);

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
